xpb_table_gen: RTL and testbench

- Runtime writer for the modular-squaring reduction lookup tables; the reduction stage reads those tables.
- Given modulus N and base B (B < N), it produces table entries T[k] = k*B mod N for k = 0..2^ADDR_W-1.
- It streams the entries in order over a valid/ready write port into the table RAM. This lets the tables be reloaded when the modulus changes, instead of being fixed at synthesis.
- Each entry is computed incrementally as T[k] = T[k-1] + B, minus N when the sum is ≥ N, using a chunk-serial add/subtract datapath.

---
 rtl/xpb_gen_pkg.sv | 27 ++
 rtl/xpb_gen_addsub.sv | 38 +++
 rtl/xpb_table_gen.sv | 177 +++++++++++++++++
 tb/tb_xpb_table_gen.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xpb_gen_pkg.sv
// Shared definitions for the XPB reduction-table generator.
//   - default operand width, table address width and datapath chunk width
//   - derived chunk count and chunk-counter width
//   - FSM state encoding shared by the generator and anything observing it
package xpb_gen_pkg;

  localparam int unsigned XPB_WIDTH  = 1024;
  localparam int unsigned XPB_ADDR_W = 5;
  localparam int unsigned XPB_CHUNK  = 64;
  localparam int unsigned XPB_NCHUNK = XPB_WIDTH / XPB_CHUNK;

  // Width of a counter that indexes nchunk chunks; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

  localparam int unsigned XPB_CNT_W = cnt_width(XPB_NCHUNK);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    ADD   = 3'd2,
    SEL   = 3'd3,
    DONE  = 3'd4
  } xpb_state_e;

endpackage

// File: rtl/xpb_gen_addsub.sv
// One CHUNK-wide slice of the serial add/subtract datapath.
// Computes s = a + b + cin and d = s - n - bin in parallel, so one pass over
// the chunks yields both the plain sum and the sum reduced by the modulus.
// Ports:
//   a, b, n  - accumulator, base and modulus chunks
//   cin, bin - carry into the add, borrow into the subtract
//   s, d     - sum chunk and difference chunk
//   cout     - carry out of the add
//   bout     - borrow out of the subtract
module xpb_gen_addsub #(
  parameter int unsigned CHUNK = 64
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [CHUNK-1:0] n,
  input  logic             cin,
  input  logic             bin,
  output logic [CHUNK-1:0] s,
  output logic [CHUNK-1:0] d,
  output logic             cout,
  output logic             bout
);

  logic [CHUNK:0] sum_ext;
  logic [CHUNK:0] diff_ext;

  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
    // A negative result wraps, leaving the top bit set: that bit is the borrow.
    diff_ext = {1'b0, sum_ext[CHUNK-1:0]} - {1'b0, n} - {{CHUNK{1'b0}}, bin};
  end

  assign s    = sum_ext[CHUNK-1:0];
  assign cout = sum_ext[CHUNK];
  assign d    = diff_ext[CHUNK-1:0];
  assign bout = diff_ext[CHUNK];

endmodule

// File: rtl/xpb_table_gen.sv
// Runtime writer for the modular-squaring reduction lookup tables.
// Produces T[k] = k*B mod N for k = 0 .. 2^ADDR_W-1 and streams the entries,
// in order, over a valid/ready write port. Each entry is derived from the
// previous one as T[k-1] + B, reduced by N when the sum reaches N, using a
// chunk-serial add/subtract datapath.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle request, honoured only when idle
//   modulus_in  - N, captured on an accepted start
//   base_in     - B (< N), captured on an accepted start
//   busy        - generation in progress, through the done cycle
//   done        - one-cycle pulse after the last entry is accepted
//   wr_valid    - table write request
//   wr_ready    - table write accept
//   wr_addr     - entry index k
//   wr_data     - entry value T[k]
module xpb_table_gen
  import xpb_gen_pkg::*;
#(
  parameter int unsigned WIDTH  = XPB_WIDTH,
  parameter int unsigned ADDR_W = XPB_ADDR_W,
  parameter int unsigned CHUNK  = XPB_CHUNK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WIDTH-1:0]  modulus_in,
  input  logic [WIDTH-1:0]  base_in,
  output logic              busy,
  output logic              done,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WIDTH-1:0]  wr_data
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);

  localparam logic [ADDR_W-1:0] LAST_K   = {ADDR_W{1'b1}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0 || NCHUNK < 2) begin : g_bad_cfg
    $error("xpb_table_gen: WIDTH must be a multiple of CHUNK with at least two chunks");
  end

  xpb_state_e state_q, state_d;

  logic [WIDTH-1:0]  n_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  acc_q;
  logic [ADDR_W-1:0] k_q;

  // Chunk fetch and compute are split into two pipeline stages so the wide
  // chunk-select mux does not sit in front of the adder carry chain. The ADD
  // phase therefore spans NCHUNK fetch cycles plus one trailing compute cycle.
  logic [CNT_W-1:0]  cnt_q;
  logic              fetch_done_q;
  logic              op_vld_q;
  logic [CHUNK-1:0]  op_a_q;
  logic [CHUNK-1:0]  op_b_q;
  logic [CHUNK-1:0]  op_n_q;

  logic              carry_q;
  logic              borrow_q;
  logic [WIDTH-1:0]  sum_q;
  logic [WIDTH-1:0]  diff_q;

  logic [CHUNK-1:0]  add_s;
  logic [CHUNK-1:0]  add_d;
  logic              add_cout;
  logic              add_bout;
  logic              sel_diff;

  xpb_gen_addsub #(
    .CHUNK (CHUNK)
  ) u_addsub (
    .a    (op_a_q),
    .b    (op_b_q),
    .n    (op_n_q),
    .cin  (carry_q),
    .bin  (borrow_q),
    .s    (add_s),
    .d    (add_d),
    .cout (add_cout),
    .bout (add_bout)
  );

  // sum >= N exactly when the add overflowed WIDTH bits or the subtract did
  // not need to borrow; acc, B < N keeps sum < 2N so one subtraction suffices.
  assign sel_diff = carry_q | ~borrow_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = WRITE;
      WRITE:   if (wr_ready) state_d = (k_q == LAST_K) ? DONE : ADD;
      ADD:     if (fetch_done_q && op_vld_q) state_d = SEL;
      SEL:     state_d = WRITE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_q          <= '0;
      b_q          <= '0;
      acc_q        <= '0;
      k_q          <= '0;
      cnt_q        <= '0;
      fetch_done_q <= 1'b0;
      op_vld_q     <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_n_q       <= '0;
      carry_q      <= 1'b0;
      borrow_q     <= 1'b0;
      sum_q        <= '0;
      diff_q       <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_q   <= modulus_in;
            b_q   <= base_in;
            acc_q <= '0;
            k_q   <= '0;
          end
        end
        WRITE: begin
          if (wr_ready && (k_q != LAST_K)) begin
            k_q          <= k_q + 1'b1;
            cnt_q        <= '0;
            fetch_done_q <= 1'b0;
            op_vld_q     <= 1'b0;
            carry_q      <= 1'b0;
            borrow_q     <= 1'b0;
          end
        end
        ADD: begin
          if (!fetch_done_q) begin
            op_a_q   <= acc_q[cnt_q*CHUNK +: CHUNK];
            op_b_q   <= b_q[cnt_q*CHUNK +: CHUNK];
            op_n_q   <= n_q[cnt_q*CHUNK +: CHUNK];
            op_vld_q <= 1'b1;
            cnt_q    <= cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) fetch_done_q <= 1'b1;
          end else begin
            op_vld_q <= 1'b0;
          end
          if (op_vld_q) begin
            // Chunks arrive LSB first; shifting in from the top leaves chunk 0
            // at the bottom once all NCHUNK results are in.
            sum_q    <= {add_s, sum_q[WIDTH-1:CHUNK]};
            diff_q   <= {add_d, diff_q[WIDTH-1:CHUNK]};
            carry_q  <= add_cout;
            borrow_q <= add_bout;
          end
        end
        SEL: begin
          acc_q <= sel_diff ? diff_q : sum_q;
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign wr_valid = (state_q == WRITE);
  assign wr_addr  = k_q;
  assign wr_data  = acc_q;

endmodule

// File: tb/tb_xpb_table_gen.sv
// Self-checking bench for xpb_table_gen: a 16-bit instance for the directed
// and randomized corner cases, and a default 1024-bit instance for the full
// width table. Expected entries come from k*B mod N computed directly.
module tb_xpb_table_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Small instance
  logic        s_start = 1'b0;
  logic [15:0] s_mod = '0;
  logic [15:0] s_base = '0;
  logic        s_busy, s_done, s_wr_valid;
  logic        s_wr_ready = 1'b1;
  logic [4:0]  s_wr_addr;
  logic [15:0] s_wr_data;

  // Default-width instance
  logic          l_start = 1'b0;
  logic [1023:0] l_mod = '0;
  logic [1023:0] l_base = '0;
  logic          l_busy, l_done, l_wr_valid;
  logic          l_wr_ready = 1'b1;
  logic [4:0]    l_wr_addr;
  logic [1023:0] l_wr_data;

  xpb_table_gen #(
    .WIDTH  (16),
    .ADDR_W (5),
    .CHUNK  (4)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (s_start),
    .modulus_in (s_mod),
    .base_in    (s_base),
    .busy       (s_busy),
    .done       (s_done),
    .wr_valid   (s_wr_valid),
    .wr_ready   (s_wr_ready),
    .wr_addr    (s_wr_addr),
    .wr_data    (s_wr_data)
  );

  xpb_table_gen u_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (l_start),
    .modulus_in (l_mod),
    .base_in    (l_base),
    .busy       (l_busy),
    .done       (l_done),
    .wr_valid   (l_wr_valid),
    .wr_ready   (l_wr_ready),
    .wr_addr    (l_wr_addr),
    .wr_data    (l_wr_data)
  );

  // Observed write handshakes and done pulses
  int            s_addr_q[$];
  logic [15:0]   s_data_q[$];
  int            s_cyc_q[$];
  int            s_done_q[$];
  int            l_addr_q[$];
  logic [1023:0] l_data_q[$];
  int            l_cyc_q[$];
  int            l_done_q[$];

  always @(negedge clk) begin
    if (s_wr_valid && s_wr_ready) begin
      s_addr_q.push_back(int'(s_wr_addr));
      s_data_q.push_back(s_wr_data);
      s_cyc_q.push_back(cyc);
    end
    if (s_done) s_done_q.push_back(cyc);
    if (l_wr_valid && l_wr_ready) begin
      l_addr_q.push_back(int'(l_wr_addr));
      l_data_q.push_back(l_wr_data);
      l_cyc_q.push_back(cyc);
    end
    if (l_done) l_done_q.push_back(cyc);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (low 128 bits)", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic logic [15:0] ref16(input int k, input logic [15:0] n, input logic [15:0] b);
    logic [31:0] p;
    p = 32'(k) * {16'b0, b};
    return 16'(p % {16'b0, n});
  endfunction

  function automatic logic [1023:0] ref_big(input int k, input logic [1023:0] n,
                                            input logic [1023:0] b);
    logic [1039:0] p;
    p = 1040'(k) * {16'b0, b};
    return 1024'(p % {16'b0, n});
  endfunction

  task automatic s_clear();
    s_addr_q.delete();
    s_data_q.delete();
    s_cyc_q.delete();
    s_done_q.delete();
  endtask

  task automatic s_pulse_start(input logic [15:0] n, input logic [15:0] b, output int st);
    @(posedge clk); #1;
    s_mod   = n;
    s_base  = b;
    s_start = 1'b1;
    st      = cyc;
    @(posedge clk); #1;
    s_start = 1'b0;
  endtask

  task automatic s_wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (s_done_q.size() > 0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic s_check_table(input string tag, input logic [15:0] n, input logic [15:0] b);
    int bad_addr;
    bad_addr = 0;
    check({tag, "_count"}, s_addr_q.size(), 32);
    check({tag, "_done_once"}, s_done_q.size(), 1);
    for (int i = 0; i < s_addr_q.size(); i++) begin
      if (s_addr_q[i] != i) bad_addr++;
      check($sformatf("%s_data%0d", tag, i), s_data_q[i], ref16(i, n, b));
    end
    check({tag, "_addr_seq"}, bad_addr, 0);
  endtask

  initial begin
    int          st;
    bit          ok;
    bit          held;
    bit          fired;
    int          bad_gap;
    logic [15:0] n, b, n2, b2;

    // ---------------- reset state ----------------
    #3 rst_n = 1'b0;
    #1;
    check("rst_busy", s_busy, 0);
    check("rst_done", s_done, 0);
    check("rst_valid", s_wr_valid, 0);
    check("rst_addr", s_wr_addr, 0);
    check("rst_data", s_wr_data, 0);
    check("rst_big_valid", l_wr_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- A: N=0xFFF1, B=0x8000 ----------------
    s_clear();
    s_pulse_start(16'hFFF1, 16'h8000, st);
    check("a_busy_after_start", s_busy, 1);
    check("a_valid_first", s_wr_valid, 1);
    s_wait_done(2000, ok);
    check("a_done_seen", ok, 1);
    check("a_busy_after_done", s_busy, 0);
    check("a_e0", s_data_q[0], 16'h0000);
    check("a_e1", s_data_q[1], 16'h8000);
    check("a_e2", s_data_q[2], 16'h000F);
    check("a_e3", s_data_q[3], 16'h800F);
    s_check_table("a", 16'hFFF1, 16'h8000);
    check("a_first_lat", s_cyc_q[0] - st, 1);
    bad_gap = 0;
    for (int i = 1; i < s_cyc_q.size(); i++) if (s_cyc_q[i] - s_cyc_q[i-1] != 7) bad_gap++;
    check("a_spacing", bad_gap, 0);
    check("a_runtime", s_done_q[0] - st + 1, 1 + 31 * 7 + 2);

    // ---------------- B: sum == N boundary ----------------
    s_clear();
    s_pulse_start(16'h000F, 16'h0005, st);
    s_wait_done(2000, ok);
    check("b_done_seen", ok, 1);
    check("b_e2", s_data_q[2], 16'h000A);
    check("b_e3_zero", s_data_q[3], 16'h0000);
    s_check_table("b", 16'h000F, 16'h0005);

    // ---------------- C: backpressure on entry 7 ----------------
    n = 16'($urandom_range(2, 16'hFFFF));
    b = 16'($urandom % n);
    s_clear();
    s_pulse_start(n, b, st);
    held = 1'b0;
    for (int i = 0; i < 2000 && s_done_q.size() == 0; i++) begin
      if (!held && s_wr_valid && s_wr_addr == 5'd7) begin
        held = 1'b1;
        s_wr_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("c_bp_valid", s_wr_valid, 1);
          check("c_bp_addr", s_wr_addr, 7);
          check("c_bp_data", s_wr_data, ref16(7, n, b));
        end
        @(posedge clk); #1;
        s_wr_ready = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("c_held", held, 1);
    check("c_done_seen", s_done_q.size() > 0, 1);
    s_check_table("c", n, b);

    // ---------------- D: start during ADD ignored ----------------
    n  = 16'($urandom_range(2, 16'hFFFF));
    b  = 16'($urandom % n);
    n2 = 16'($urandom_range(2, 16'hFFFF));
    if (n2 == n) n2 = n ^ 16'h8000;
    if (n2 < 16'd2) n2 = 16'd3;
    b2 = 16'($urandom % n2);
    s_clear();
    s_pulse_start(n, b, st);
    fired = 1'b0;
    for (int i = 0; i < 2000 && s_done_q.size() == 0; i++) begin
      if (!fired && s_addr_q.size() == 4) begin
        fired = 1'b0;
        @(posedge clk); #1;
        check("d_in_add", s_wr_valid, 0);
        s_mod   = n2;
        s_base  = b2;
        s_start = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        fired   = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("d_fired", fired, 1);
    s_check_table("d_orig", n, b);
    s_clear();
    s_pulse_start(n2, b2, st);
    s_wait_done(2000, ok);
    check("d_new_done", ok, 1);
    s_check_table("d_new", n2, b2);

    // ---------------- E: reset during ADD of entry 10 ----------------
    n = 16'($urandom_range(2, 16'hFFFF));
    b = 16'($urandom % n);
    s_clear();
    s_pulse_start(n, b, st);
    fired = 1'b0;
    for (int i = 0; i < 2000 && !fired; i++) begin
      if (s_addr_q.size() == 10) begin
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("e_rst_busy", s_busy, 0);
        check("e_rst_done", s_done, 0);
        check("e_rst_valid", s_wr_valid, 0);
        check("e_rst_addr", s_wr_addr, 0);
        check("e_rst_data", s_wr_data, 0);
        fired = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    check("e_fired", fired, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    s_clear();
    repeat (20) @(posedge clk);
    #1;
    check("e_no_write", s_addr_q.size(), 0);
    check("e_no_done", s_done_q.size(), 0);
    s_pulse_start(n, b, st);
    s_wait_done(2000, ok);
    check("e_restart_done", ok, 1);
    s_check_table("e", n, b);

    // ---------------- F: default width, random N and B ----------------
    begin
      logic [1023:0] bn, bb;
      int            lst;
      bit            lok;
      int            bad_addr;
      for (int w = 0; w < 32; w++) begin
        bn[w*32 +: 32] = $urandom;
        bb[w*32 +: 32] = $urandom;
      end
      bn[1023] = 1'b1;
      bn[0]    = 1'b1;
      bb       = bb % bn;
      l_addr_q.delete();
      l_data_q.delete();
      l_cyc_q.delete();
      l_done_q.delete();
      @(posedge clk); #1;
      l_mod   = bn;
      l_base  = bb;
      l_start = 1'b1;
      lst     = cyc;
      @(posedge clk); #1;
      l_start = 1'b0;
      lok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (l_done_q.size() > 0) begin
          lok = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      check("f_done_seen", lok, 1);
      check("f_count", l_addr_q.size(), 32);
      check("f_done_once", l_done_q.size(), 1);
      check("f_first_lat", l_cyc_q[0] - lst, 1);
      check("f_runtime", l_done_q[0] - lst + 1, 592);
      bad_addr = 0;
      for (int i = 0; i < l_addr_q.size(); i++) begin
        if (l_addr_q[i] != i) bad_addr++;
        check($sformatf("f_data%0d", i), l_data_q[i], ref_big(i, bn, bb));
      end
      check("f_addr_seq", bad_addr, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
